// File: rtl/tmr_voter_if.sv
// tmr_voter_if: per-core ALU/store/write-enable inputs and voted outputs of the TMR voter
interface tmr_voter_if #(parameter int CNT_W = 8);
    logic [31:0] alu_a, alu_b, alu_c;
    logic [31:0] wd_a, wd_b, wd_c;
    logic we_a, we_b, we_c;
    logic clr_fault;
    logic [31:0] alu_v, wd_v;
    logic we_v;
    logic [2:0] mismatch, failed;
    logic [1:0] state;
    logic [CNT_W-1:0] err_cnt_a, err_cnt_b, err_cnt_c;
    modport master(
        output alu_a, alu_b, alu_c, wd_a, wd_b, wd_c, we_a, we_b, we_c, clr_fault,
        input alu_v, wd_v, we_v, mismatch, failed, state, err_cnt_a, err_cnt_b, err_cnt_c
    );
    modport slave(
        input alu_a, alu_b, alu_c, wd_a, wd_b, wd_c, we_a, we_b, we_c, clr_fault,
        output alu_v, wd_v, we_v, mismatch, failed, state, err_cnt_a, err_cnt_b, err_cnt_c
    );
endinterface

// File: rtl/tmr_voter.sv
// tmr_voter: triple-modular-redundancy voter with degrade/fail handling; TMR_VOTER_STATS_EN adds per-core error counters
module tmr_voter #(
    parameter int THRESH = 4,
    parameter int CNT_W  = 8
) (
    input logic clk,
    input logic rst_in,
    tmr_voter_if.slave io_bus
);
    typedef enum logic [1:0] {TRIPLE = 2'b00, DEGRADED = 2'b01, FAIL = 2'b10} state_t;
    state_t r_state, w_nxt;
    logic [64:0] w_b [3];
    logic [64:0] w_maj, w_h0, w_h1, w_hf, w_out;
    logic [2:0] w_tmm, w_dmm, w_hit, w_mm, w_fail_nxt;
    logic [2:0] r_failed, r_mm;
    logic [2:0][CNT_W-1:0] w_ec;
    logic w_two, w_agree, w_hold;
    logic [31:0] r_alu, r_wd;
    logic r_we;
    assign w_b[0] = {io_bus.we_a, io_bus.alu_a, io_bus.wd_a};
    assign w_b[1] = {io_bus.we_b, io_bus.alu_b, io_bus.wd_b};
    assign w_b[2] = {io_bus.we_c, io_bus.alu_c, io_bus.wd_c};
    assign w_maj = (w_b[0] & w_b[1]) | (w_b[0] & w_b[2]) | (w_b[1] & w_b[2]);
    assign w_two = (w_tmm[0] & w_tmm[1]) | (w_tmm[0] & w_tmm[2]) | (w_tmm[1] & w_tmm[2]);
    // with exactly one failed core, h0/h1 are the two survivors and hf the failed one
    assign w_h0 = r_failed[0] ? w_b[1] : w_b[0];
    assign w_h1 = r_failed[2] ? w_b[1] : w_b[2];
    assign w_hf = r_failed[0] ? w_b[0] : (r_failed[1] ? w_b[1] : w_b[2]);
    assign w_agree = w_h0 == w_h1;
    assign w_dmm = w_agree ? (r_failed & {3{w_hf != w_h0}}) : ~r_failed;
    for (genvar i = 0; i < 3; i++) begin : g_core
        logic [3:0] r_cc;
        logic [3:0] w_inc;
        assign w_tmm[i] = w_b[i] != w_maj;
        assign w_inc = r_cc + 4'd1;
        assign w_hit[i] = w_tmm[i] && (w_inc == 4'(THRESH));
        always_ff @(posedge clk) begin
            if (rst_in || io_bus.clr_fault) r_cc <= '0;
            else if (r_state == TRIPLE) r_cc <= w_tmm[i] ? w_inc : '0;
        end
`ifdef TMR_VOTER_STATS_EN
        logic [CNT_W-1:0] r_ec;
        always_ff @(posedge clk) begin
            if (rst_in) r_ec <= '0;
            else if (!io_bus.clr_fault && w_mm[i] && r_ec != '1) r_ec <= r_ec + 1'b1;
        end
        assign w_ec[i] = r_ec;
`else
        assign w_ec[i] = '0;
`endif
    end
    always_comb begin
        w_mm = '0;
        w_out = w_maj;
        w_hold = 1'b0;
        w_nxt = r_state;
        w_fail_nxt = r_failed;
        unique case (r_state)
            TRIPLE: begin
                w_mm = w_tmm;
                w_hold = w_two;
                w_fail_nxt = r_failed | w_hit;
                w_nxt = w_two ? FAIL : ((|w_hit) ? DEGRADED : TRIPLE);
            end
            DEGRADED: begin
                w_mm = w_dmm;
                w_out = w_h0;
                w_hold = !w_agree;
                w_nxt = w_agree ? DEGRADED : FAIL;
            end
            default: w_hold = 1'b1;
        endcase
        if (io_bus.clr_fault) begin
            w_nxt = TRIPLE;
            w_fail_nxt = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state <= TRIPLE;
            r_failed <= '0;
            r_mm <= '0;
            r_we <= 1'b0;
            r_alu <= '0;
            r_wd <= '0;
        end else begin
            r_state <= w_nxt;
            r_failed <= w_fail_nxt;
            r_mm <= w_mm;
            r_we <= !w_hold && w_out[64];
            if (!w_hold) {r_alu, r_wd} <= w_out[63:0];
        end
    end
    assign io_bus.alu_v = r_alu;
    assign io_bus.wd_v = r_wd;
    assign io_bus.we_v = r_we;
    assign io_bus.mismatch = r_mm;
    assign io_bus.failed = r_failed;
    assign io_bus.state = r_state;
    assign io_bus.err_cnt_a = w_ec[0];
    assign io_bus.err_cnt_b = w_ec[1];
    assign io_bus.err_cnt_c = w_ec[2];
endmodule

// File: tb/tb_tmr_voter.sv
// tb_tmr_voter: randomized scoreboard bench for tmr_voter against a behavioural voting model
module tb_tmr_voter;
    localparam int THRESH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX = (1 << CNT_W) - 1;
    localparam bit STATS =
`ifdef TMR_VOTER_STATS_EN
        1'b1;
`else
        1'b0;
`endif
    localparam logic [64:0] G = {1'b1, 32'h0000_1234, 32'hA5A5_A5A5};
    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic we;
        logic [2:0] mm;
        logic [2:0] failed;
        logic [1:0] st;
        logic [2:0][CNT_W-1:0] ec;
    } exp_t;
    logic clk = 1'b0;
    logic rst_in;
    int n_chk = 0;
    int n_fail = 0;
    exp_t sbq[$];
    int m_st;
    logic [2:0] m_failed, m_mm;
    int m_cc[3];
    int m_ec[3];
    logic [31:0] m_alu, m_wd;
    logic m_we;
    always #5 clk = ~clk;
    tmr_voter_if #(.CNT_W(CNT_W)) bus();
    tmr_voter #(.THRESH(THRESH), .CNT_W(CNT_W)) dut(.clk(clk), .rst_in(rst_in), .io_bus(bus));
    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction
    task automatic step(input bit rst, input bit clr, input logic [64:0] a, input logic [64:0] b, input logic [64:0] c);
        logic [64:0] bn[3];
        logic [64:0] maj, outv;
        logic [2:0] mm, fl;
        int nx, n, f, p, q;
        bit hold, reached;
        exp_t e;
        @(negedge clk);
        rst_in = rst;
        bus.clr_fault = clr;
        {bus.we_a, bus.alu_a, bus.wd_a} = a;
        {bus.we_b, bus.alu_b, bus.wd_b} = b;
        {bus.we_c, bus.alu_c, bus.wd_c} = c;
        bn = '{a, b, c};
        if (rst) begin
            m_st = 0; m_failed = '0; m_mm = '0; m_we = 1'b0; m_alu = '0; m_wd = '0;
            for (int i = 0; i < 3; i++) begin m_cc[i] = 0; m_ec[i] = 0; end
        end else begin
            maj = '0;
            for (int k = 0; k < 65; k++) maj[k] = (int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2;
            mm = '0; hold = 0; outv = maj; nx = m_st; fl = m_failed; reached = 0;
            if (m_st == 0) begin
                n = 0;
                for (int i = 0; i < 3; i++) if (bn[i] != maj) begin mm[i] = 1'b1; n++; end
                hold = n >= 2;
                for (int i = 0; i < 3; i++) begin
                    m_cc[i] = mm[i] ? m_cc[i] + 1 : 0;
                    if (m_cc[i] == THRESH) begin fl[i] = 1'b1; reached = 1; end
                end
                nx = hold ? 2 : (reached ? 1 : 0);
            end else if (m_st == 1) begin
                f = 0; p = -1; q = -1;
                for (int i = 0; i < 3; i++)
                    if (m_failed[i]) f = i; else if (p < 0) p = i; else q = i;
                if (bn[p] == bn[q]) begin
                    outv = bn[p];
                    mm[f] = bn[f] != outv;
                end else begin
                    hold = 1; mm[p] = 1'b1; mm[q] = 1'b1; nx = 2;
                end
            end else hold = 1;
            if (clr) begin
                nx = 0; fl = '0;
                for (int i = 0; i < 3; i++) m_cc[i] = 0;
            end else begin
                for (int i = 0; i < 3; i++) if (mm[i] && m_ec[i] < CMAX) m_ec[i]++;
            end
            m_mm = mm;
            m_we = hold ? 1'b0 : outv[64];
            if (!hold) begin m_alu = outv[63:32]; m_wd = outv[31:0]; end
            m_st = nx; m_failed = fl;
        end
        e.alu = m_alu; e.wd = m_wd; e.we = m_we; e.mm = m_mm; e.failed = m_failed; e.st = 2'(m_st);
        for (int i = 0; i < 3; i++) e.ec[i] = STATS ? CNT_W'(m_ec[i]) : '0;
        sbq.push_back(e);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("alu_v", bus.alu_v, e.alu);
                chk("wd_v", bus.wd_v, e.wd);
                chk("we_v", bus.we_v, e.we);
                chk("mismatch", bus.mismatch, e.mm);
                chk("failed", bus.failed, e.failed);
                chk("state", bus.state, e.st);
                chk("err_cnt_a", bus.err_cnt_a, e.ec[0]);
                chk("err_cnt_b", bus.err_cnt_b, e.ec[1]);
                chk("err_cnt_c", bus.err_cnt_c, e.ec[2]);
            end
        end
    end
    function automatic logic [64:0] flip(input logic [64:0] x);
        return x ^ (65'h1 << $urandom_range(64));
    endfunction
    initial begin
        logic [64:0] base, ra, rb, rc;
        int bad;
        repeat (2) step(1, 0, G, G, G);
        step(0, 0, G, G, G);
        repeat (3) step(0, 0, G, G ^ (65'h1 << 32), G);
        repeat (2) step(0, 0, G, G, G);
        repeat (4) step(0, 0, G, G, G ^ (65'h1 << 64));
        repeat (2) step(0, 0, G, G, G);
        step(0, 0, G, G, G ^ 65'h3);
        step(0, 0, {1'b1, 32'd5, 32'hA5A5_A5A5}, {1'b1, 32'd6, 32'hA5A5_A5A5}, G);
        repeat (2) step(0, 0, G, G, G);
        step(0, 1, G, G, G);
        step(0, 0, G, G, G);
        step(0, 0, {1'b1, 32'h1, 32'h0}, {1'b1, 32'h2, 32'h0}, {1'b1, 32'h3, 32'h0});
        step(0, 0, G, G, G);
        step(0, 1, G, G ^ 65'h10, G ^ 65'h20);
        step(0, 0, G, G, G);
        for (int s = 0; s < 40; s++) begin
            bad = $urandom_range(2);
            base = {$urandom, $urandom, $urandom};
            for (int t = 0; t < 50; t++) begin
                if ($urandom_range(3) == 0) base = {$urandom, $urandom, $urandom};
                ra = ($urandom_range(bad == 0 ? 3 : 9) < (bad == 0 ? 3 : 1)) ? flip(base) : base;
                rb = ($urandom_range(bad == 1 ? 3 : 9) < (bad == 1 ? 3 : 1)) ? flip(base) : base;
                rc = ($urandom_range(bad == 2 ? 3 : 9) < (bad == 2 ? 3 : 1)) ? flip(base) : base;
                step($urandom_range(399) == 0, $urandom_range(39) == 0, ra, rb, rc);
            end
        end
        step(1, 0, G, G, G);
        repeat (200) step(0, 0, G, G, G ^ (65'h1 << 40));
        step(0, 0, G ^ 65'h1, G ^ 65'h2, G);
        step(0, 0, G, G, G);
        step(1, 1, G ^ 65'h1, G ^ 65'h2, G ^ 65'h4);
        step(0, 0, G, G, G);
        repeat (300) step(0, 0, G ^ (65'h1 << 7), G, G);
        repeat (2) step(0, 0, G, G, G);
        repeat (4) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tmr_voter.md
TMR_VOTER -- requirements
Module: tmr_voter

Interface
REQ-001 Parameter THRESH, default 4, is the number of consecutive mismatching cycles after which a core is declared failed (legal range 1..15).
REQ-002 Parameter CNT_W, default 8, is the width of each per-core total-error counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset; synchronous, active-high.
REQ-005 alu_a/alu_b/alu_c  input  32 each  ALUResult of cores A/B/C.
REQ-006 wd_a/wd_b/wd_c  input  32 each  store data (RD2) of cores A/B/C.
REQ-007 we_a/we_b/we_c  input  1 each  MemWrite of cores A/B/C.
REQ-008 clr_fault  input  1  clears failed-core mask and returns to TRIPLE.
REQ-009 alu_v  output  32  voted ALUResult, registered.
REQ-010 wd_v  output  32  voted store data, registered.
REQ-011 we_v  output  1  voted MemWrite, registered.
REQ-012 mismatch  output  3  per-core mismatch in the last voted cycle, bit0=A, bit1=B, bit2=C, registered.
REQ-013 failed  output  3  sticky failed-core mask, same bit order.
REQ-014 state  output  2  00=TRIPLE, 01=DEGRADED, 10=FAIL.
REQ-015 err_cnt_a/err_cnt_b/err_cnt_c  output  CNT_W each  total mismatch counts.

Function
REQ-016 Bundle per core = {we, alu, wd} (65 bits); voting is bitwise majority over the three bundles.
REQ-017 A core mismatches in a cycle when its bundle differs from the bitwise-majority bundle in any bit.
REQ-018 All voted outputs appear exactly 1 cycle after their inputs (one register stage).
REQ-019 TRIPLE: outputs = bitwise majority; mismatch = per-core compare result.
REQ-020 Each core has a consecutive-mismatch counter: +1 on mismatch, cleared on match; on reaching THRESH the core's failed bit sets and state goes to DEGRADED on the next cycle.
REQ-021 TRIPLE with two or more cores mismatching in the same cycle -> FAIL next cycle; in that cycle we_v = 0 and alu_v/wd_v hold their previous values.
REQ-022 TRIPLE with two counters reaching THRESH in the same cycle -> FAIL.
REQ-023 DEGRADED: outputs taken from the two non-failed cores; if their bundles are equal, outputs = that bundle; the failed core's mismatch bit still reports its compare against that bundle.
REQ-024 DEGRADED with the two healthy cores disagreeing -> FAIL next cycle; that cycle we_v = 0 and alu_v/wd_v hold.
REQ-025 FAIL: we_v forced 0, alu_v/wd_v frozen at the last good value, mismatch = 000; exit only via clr_fault or rst_in.
REQ-026 clr_fault = 1: next cycle state = TRIPLE, failed = 000, consecutive counters = 0; a mismatch in the same cycle is neither counted nor acted on.
REQ-027 err_cnt_x increments by 1 per mismatching cycle of core x in TRIPLE or DEGRADED, saturates at 2^CNT_W-1, and is unaffected by clr_fault.
REQ-028 A failed core never re-enters voting without clr_fault, even if it matches again.

Reset
REQ-029 rst_in = 1 at a clock edge: state = TRIPLE, alu_v = wd_v = 0, we_v = 0, mismatch = 000, failed = 000, all counters 0.
REQ-030 Reset has priority over clr_fault and over any mismatch in the same cycle.

Configuration
REQ-031 Macro TMR_VOTER_STATS_EN defined: err_cnt_a/b/c are implemented as specified.
REQ-032 TMR_VOTER_STATS_EN undefined: no total-error counter registers exist, err_cnt_a/b/c are tied to 0, and all other behaviour is identical.

Verification
REQ-033 All three cores carry alu=0x0000_1234, wd=0xA5A5_A5A5, we=1 -> next cycle alu_v=0x1234, wd_v=0xA5A5A5A5, we_v=1, mismatch=000, state=TRIPLE.
REQ-034 Core B alu bit 0 flipped for 3 cycles, then clean (THRESH=4) -> alu_v always correct, mismatch=010 for 3 cycles, failed=000, err_cnt_b=3.
REQ-035 Core C we inverted for 4 consecutive cycles -> failed=100, state=DEGRADED, we_v follows A/B throughout.
REQ-036 In DEGRADED with C failed, A alu=5 and B alu=6 -> next cycle state=FAIL, we_v=0, alu_v holds the prior value; clr_fault pulse -> state=TRIPLE, failed=000.
REQ-037 A and B both differ from the majority in one cycle (bitwise majority 0x3 from A=0x1, B=0x2, C=0x3) -> state=FAIL, we_v=0.
REQ-038 rst_in asserted while in FAIL with err_cnt_c=200 -> all outputs 0, state=TRIPLE, err_cnt_c=0; 300 mismatches on core A with CNT_W=8 -> err_cnt_a=255.
